display_scan_ctrl: RTL



---
 rtl/display_pkg.sv | 9 +
 rtl/display_scan_ctrl_if.sv | 13 +
 rtl/display_scan_ctrl_slot_timer.sv | 17 +
 rtl/display_scan_ctrl.sv | 74 +++++++
 4 files changed

// File: rtl/display_pkg.sv
// display_pkg: shared types and constants for the 4-digit scan controller.
package display_pkg;
  typedef enum logic {BLANK, SHOW} scan_state_t;
  localparam int NUM_DIGITS = 4;
  localparam int NIBBLE_W = 4;
  function automatic logic [NIBBLE_W-1:0] nibble(input logic [NUM_DIGITS*NIBBLE_W-1:0] v, input logic [1:0] d);
    return v[{d, 2'b00} +: NIBBLE_W];
  endfunction
endpackage

// File: rtl/display_scan_ctrl_if.sv
// display_scan_ctrl_if: value/strobe inputs and registered digit-drive outputs of the scan controller.
interface display_scan_ctrl_if;
  import display_pkg::*;
  logic [NUM_DIGITS*NIBBLE_W-1:0] value;
  logic                           load;
  logic [NUM_DIGITS-1:0]          digit_en;
  logic [1:0]                     digit;
  logic [NIBBLE_W-1:0]            disp_digit;
  logic                           blank;
  logic                           frame_done;
  modport master (output value, load, digit_en, input digit, disp_digit, blank, frame_done);
  modport slave (input value, load, digit_en, output digit, disp_digit, blank, frame_done);
endinterface

// File: rtl/display_scan_ctrl_slot_timer.sv
// slot_timer: down-counter that reloads ld_val and pulses tc when it reaches zero.
module slot_timer #(
  parameter int W = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] ld_val,
  output logic         tc
);
  logic [W-1:0] cnt_q, cnt_d;
  assign tc = cnt_q == '0;
  always_comb cnt_d = tc ? ld_val : cnt_q - W'(1);
  always_ff @(posedge clk)
    if (reset) cnt_q <= RST_VAL;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: blank/show digit scheduler with frame-synchronous value update.
// Optional LEADING_ZERO_SUPPRESS_EN blanks leading zero digits (digit 0 always shown).
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int DWELL_CYCLES = 12500,
  parameter int BLANK_CYCLES = 500
) (
  input logic clk,
  input logic reset,
  display_scan_ctrl_if.slave io
);
  localparam int MAXC = DWELL_CYCLES > BLANK_CYCLES ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] DWELL_LD = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LD = CW'(BLANK_CYCLES > 0 ? BLANK_CYCLES - 1 : 0);
  localparam scan_state_t FIRST = BLANK_CYCLES > 0 ? BLANK : SHOW;
  scan_state_t state_q, state_d;
  logic [1:0] digit_q, digit_d;
  logic [NIBBLE_W-1:0] disp_digit_q, disp_digit_d;
  logic blank_q, blank_d, frame_done_q, frame_done_d;
  logic [NUM_DIGITS*NIBBLE_W-1:0] active_q, active_d, pending_q, pending_d;
  logic pending_valid_q, pending_valid_d;
  logic tc, end_show, suppress;
  logic [CW-1:0] ld_val;
  slot_timer #(.W(CW), .RST_VAL(BLANK_CYCLES > 0 ? BLANK_LD : DWELL_LD)) u_timer (
    .clk(clk), .reset(reset), .ld_val(ld_val), .tc(tc)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FIRST;
      digit_q <= '0;
      disp_digit_q <= '0;
      blank_q <= 1'b1;
      frame_done_q <= 1'b0;
      active_q <= '0;
      pending_q <= '0;
      pending_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      disp_digit_q <= disp_digit_d;
      blank_q <= blank_d;
      frame_done_q <= frame_done_d;
      active_q <= active_d;
      pending_q <= pending_d;
      pending_valid_q <= pending_valid_d;
    end
  end
  // The timer is reloaded with the length of whichever state follows its terminal count.
  always_comb begin
    end_show = tc && state_q == SHOW;
    state_d = tc ? ((state_q == SHOW && BLANK_CYCLES > 0) ? BLANK : SHOW) : state_q;
    digit_d = end_show ? digit_q + 2'd1 : digit_q;
    ld_val = state_d == BLANK ? BLANK_LD : DWELL_LD;
    frame_done_d = end_show && digit_q == 2'(NUM_DIGITS - 1);
    pending_d = io.load ? io.value : pending_q;
    pending_valid_d = !frame_done_q && (pending_valid_q || io.load);
    active_d = !frame_done_q ? active_q : io.load ? io.value : pending_valid_q ? pending_q : active_q;
  end
`ifdef LEADING_ZERO_SUPPRESS_EN
  assign suppress = digit_d != 2'd0 && (active_d >> {digit_d, 2'b00}) == '0;
`else
  assign suppress = 1'b0;
`endif
  always_comb begin
    blank_d = state_d == BLANK || !io.digit_en[digit_d] || suppress;
    disp_digit_d = nibble(active_d, digit_d);
  end
  assign io.digit = digit_q;
  assign io.disp_digit = disp_digit_q;
  assign io.blank = blank_q;
  assign io.frame_done = frame_done_q;
endmodule
